// File: rtl/waveform_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | waveform_bank: multi-slot waveform store with AXI-Stream record/replay.  |
// | Optional WFBANK_KEEP_CHECK_EN: partial tkeep on a write beat is an error |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module waveform_bank #(
    parameter  int DATA_W    = 32,
    parameter  int SLOT_AW   = 9,
    parameter  int NUM_SLOTS = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                  clk_in1,
    input  logic                  aresetn,
    input  logic                  wr_start,
    input  logic [SLOT_W-1:0]     wr_slot,
    input  logic [SLOT_AW:0]      wr_len,
    input  logic                  play_start,
    input  logic [SLOT_W-1:0]     play_slot,
    input  logic [7:0]            play_repeat,
    input  logic                  play_stop,
    output logic                  wr_busy,
    output logic                  play_busy,
    output logic [NUM_SLOTS-1:0]  slot_valid,
    output logic                  err_len,
    output logic                  err_slot,
    input  logic [DATA_W-1:0]     wfin_axis_tdata,
    input  logic                  wfin_axis_tvalid,
    input  logic                  wfin_axis_tlast,
    input  logic [DATA_W/8-1:0]   wfin_axis_tkeep,
    output logic                  wfin_axis_tready,
    output logic [DATA_W-1:0]     wfout_axis_tdata,
    output logic                  wfout_axis_tvalid,
    output logic                  wfout_axis_tlast,
    output logic [DATA_W/8-1:0]   wfout_axis_tkeep,
    input  logic                  wfout_axis_tready
);

    localparam int DEPTH = NUM_SLOTS << SLOT_AW;
    localparam logic [SLOT_AW:0]   c_len_one = 1;
    localparam logic [SLOT_AW-1:0] c_idx_one = 1;

    typedef enum logic [2:0] {IDLE, WR_DATA, RD_FILL, RD_DATA, RD_FLUSH} state_t;
    state_t r_state;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [SLOT_AW:0]   r_slot_len [NUM_SLOTS];
    logic [SLOT_W-1:0]  r_wr_slot, r_rd_slot;
    logic [SLOT_AW:0]   r_wr_len, r_wr_cnt, r_rd_len;
    logic [SLOT_AW-1:0] r_rd_idx;
    logic [7:0]         r_rep;
    logic               r_stop, r_inflight, r_rd_last;
    logic [DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]  r_fifo_data [2];
    logic [1:0]         r_fifo_last;
    logic               r_wptr, r_rptr;
    logic [1:0]         r_count;

    logic               w_wr_beat, w_len_hit, w_keep_bad, w_wr_end;
    logic [SLOT_AW:0]   w_cnt_next;
    logic               w_rd_active, w_pop, w_push, w_issue, w_idx_last, w_final;
    logic [2:0]         w_occ;

`ifdef WFBANK_KEEP_CHECK_EN
    assign w_keep_bad = (wfin_axis_tkeep != '1);
`else
    logic w_unused_keep;
    assign w_unused_keep = ^wfin_axis_tkeep;
    assign w_keep_bad    = 1'b0;
`endif

    assign w_wr_beat  = wfin_axis_tready & wfin_axis_tvalid;
    assign w_cnt_next = r_wr_cnt + c_len_one;
    assign w_len_hit  = (w_cnt_next == r_wr_len);
    assign w_wr_end   = w_wr_beat & (w_len_hit | wfin_axis_tlast | w_keep_bad);

    // Two-entry output FIFO fed by a one-cycle RAM read; reads are issued only
    // when the FIFO plus the in-flight word still fit, giving full throughput.
    assign w_rd_active = (r_state == RD_FILL) || (r_state == RD_DATA);
    assign wfout_axis_tvalid = (r_state == RD_DATA) && (r_count != 2'd0);
    assign wfout_axis_tdata  = r_fifo_data[r_rptr];
    assign wfout_axis_tlast  = wfout_axis_tvalid & r_fifo_last[r_rptr];
    assign wfout_axis_tkeep  = '1;
    assign w_pop      = wfout_axis_tvalid & wfout_axis_tready;
    assign w_push     = r_inflight & w_rd_active;
    assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue    = w_rd_active && (w_occ < (3'd2 + {2'b00, w_pop}));
    assign w_idx_last = ({1'b0, r_rd_idx} == (r_rd_len - c_len_one));
    assign w_final    = w_pop & wfout_axis_tlast & ((r_rep == 8'd1) | r_stop | play_stop);

    always_ff @(posedge clk_in1) begin
        if (w_wr_beat)
            r_mem[{r_wr_slot, r_wr_cnt[SLOT_AW-1:0]}] <= wfin_axis_tdata;
        if (w_issue)
            r_rd_data <= r_mem[{r_rd_slot, r_rd_idx}];
        if (w_push)
            r_fifo_data[r_wptr] <= r_rd_data;
    end

    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            r_state          <= IDLE;
            wr_busy          <= 1'b0;
            play_busy        <= 1'b0;
            slot_valid       <= '0;
            err_len          <= 1'b0;
            err_slot         <= 1'b0;
            wfin_axis_tready <= 1'b0;
            r_wr_slot        <= '0;
            r_rd_slot        <= '0;
            r_wr_len         <= '0;
            r_wr_cnt         <= '0;
            r_rd_len         <= '0;
            r_rd_idx         <= '0;
            r_rep            <= '0;
            r_stop           <= 1'b0;
            r_inflight       <= 1'b0;
            r_rd_last        <= 1'b0;
            r_fifo_last      <= '0;
            r_wptr           <= 1'b0;
            r_rptr           <= 1'b0;
            r_count          <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                r_slot_len[i] <= '0;
        end else begin
            err_len    <= 1'b0;
            err_slot   <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_last <= w_idx_last;
                r_rd_idx  <= w_idx_last ? '0 : r_rd_idx + c_idx_one;
            end
            if (w_push) begin
                r_fifo_last[r_wptr] <= r_rd_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
                IDLE: begin
                    if (wr_start) begin
                        r_wr_slot           <= wr_slot;
                        r_wr_len            <= wr_len;
                        r_wr_cnt            <= '0;
                        slot_valid[wr_slot] <= 1'b0;
                        wfin_axis_tready    <= 1'b1;
                        wr_busy             <= 1'b1;
                        r_state             <= WR_DATA;
                    end else if (play_start) begin
                        if (slot_valid[play_slot]) begin
                            r_rd_slot <= play_slot;
                            r_rd_len  <= r_slot_len[play_slot];
                            r_rep     <= play_repeat;
                            r_stop    <= 1'b0;
                            r_rd_idx  <= '0;
                            play_busy <= 1'b1;
                            r_state   <= RD_FILL;
                        end else begin
                            err_slot <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_wr_beat)
                        r_wr_cnt <= w_cnt_next;
                    if (w_wr_end) begin
                        r_slot_len[r_wr_slot] <= w_cnt_next;
                        slot_valid[r_wr_slot] <= 1'b1;
                        err_len               <= w_keep_bad | (wfin_axis_tlast != w_len_hit);
                        wfin_axis_tready      <= 1'b0;
                        wr_busy               <= 1'b0;
                        r_state               <= IDLE;
                    end
                end
                RD_FILL: begin
                    if (play_stop)
                        r_stop <= 1'b1;
                    r_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (play_stop)
                        r_stop <= 1'b1;
                    if (w_pop && wfout_axis_tlast && (r_rep != 8'd0))
                        r_rep <= r_rep - 8'd1;
                    if (w_final)
                        r_state <= RD_FLUSH;
                end
                RD_FLUSH: begin
                    // Words prefetched past the final tlast are dropped here.
                    r_count   <= '0;
                    r_wptr    <= 1'b0;
                    r_rptr    <= 1'b0;
                    r_rep     <= '0;
                    play_busy <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    wr_busy          <= 1'b0;
                    play_busy        <= 1'b0;
                    wfin_axis_tready <= 1'b0;
                    r_state          <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_waveform_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_waveform_bank: scoreboard bench for waveform_bank record/replay.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_waveform_bank;

    localparam int DATA_W = 32;
    localparam int SLOT_AW = 9;
    localparam int NUM_SLOTS = 4;

    logic        clk_in1 = 1'b0;
    logic        aresetn = 1'b0;
    logic        wr_start = 1'b0, play_start = 1'b0, play_stop = 1'b0;
    logic [1:0]  wr_slot = '0, play_slot = '0;
    logic [SLOT_AW:0] wr_len = '0;
    logic [7:0]  play_repeat = '0;
    logic        wr_busy, play_busy, err_len, err_slot;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [DATA_W-1:0] in_tdata = '0;
    logic        in_tvalid = 1'b0, in_tlast = 1'b0, in_tready;
    logic [3:0]  in_tkeep = 4'hF;
    logic [DATA_W-1:0] out_tdata;
    logic        out_tvalid, out_tlast;
    logic [3:0]  out_tkeep;
    logic        out_tready = 1'b1;

    int checks = 0, errors = 0;
    int err_len_cnt = 0, err_slot_cnt = 0, busy_seen = 0, tvalid_seen = 0;
    bit rnd_ready = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    waveform_bank #(.DATA_W(DATA_W), .SLOT_AW(SLOT_AW), .NUM_SLOTS(NUM_SLOTS)) dut (
        .clk_in1(clk_in1), .aresetn(aresetn),
        .wr_start(wr_start), .wr_slot(wr_slot), .wr_len(wr_len),
        .play_start(play_start), .play_slot(play_slot), .play_repeat(play_repeat),
        .play_stop(play_stop),
        .wr_busy(wr_busy), .play_busy(play_busy), .slot_valid(slot_valid),
        .err_len(err_len), .err_slot(err_slot),
        .wfin_axis_tdata(in_tdata), .wfin_axis_tvalid(in_tvalid),
        .wfin_axis_tlast(in_tlast), .wfin_axis_tkeep(in_tkeep),
        .wfin_axis_tready(in_tready),
        .wfout_axis_tdata(out_tdata), .wfout_axis_tvalid(out_tvalid),
        .wfout_axis_tlast(out_tlast), .wfout_axis_tkeep(out_tkeep),
        .wfout_axis_tready(out_tready)
    );

    always #5 clk_in1 = ~clk_in1;

    initial forever begin
        @(posedge clk_in1);
        #1;
        out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk_in1) begin
        if (aresetn) begin
            if (err_len)    err_len_cnt++;
            if (err_slot)   err_slot_cnt++;
            if (play_busy)  busy_seen++;
            if (out_tvalid) tvalid_seen++;
            if (stall_prev) begin
                checks++;
                if (!out_tvalid || out_tdata != prev_data || out_tlast != prev_last) begin
                    errors++;
                    $display("FAIL hold_stable got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                             out_tvalid, out_tdata, out_tlast, prev_data, prev_last);
                end
            end
            if (out_tvalid && out_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word got d=%0h l=%0b expected none", out_tdata, out_tlast);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({out_tlast, out_tdata} != mon_exp || out_tkeep != 4'hF) begin
                        errors++;
                        $display("FAIL out_word got l=%0b d=%0h k=%0h expected l=%0b d=%0h k=f",
                                 out_tlast, out_tdata, out_tkeep, mon_exp[32], mon_exp[31:0]);
                    end
                end
            end
            stall_prev = out_tvalid && !out_tready;
            prev_data  = out_tdata;
            prev_last  = out_tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in1);
        #2;
    endtask

    task automatic push_words(input int base, input int n, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
                exp_q.push_back({1'(i == n - 1), 32'(base + i)});
    endtask

    // Sends nbeats words; abort_at >= 0 leaves the write hanging before that beat.
    task automatic write_slot(input int slot, input int len, input int nbeats,
                              input int tlast_at, input int base, input int abort_at);
        int t;
        err_len_cnt = 0;
        wr_slot = 2'(slot); wr_len = 10'(len); wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (k == abort_at) return;
            in_tvalid = 1'b1; in_tdata = 32'(base + k); in_tlast = (k == tlast_at);
            t = 0;
            while (!in_tready && t < 50) begin step(); t++; end
            chk("wr_tready_timeout", {63'd0, in_tready}, 64'd1);
            step();
        end
        in_tvalid = 1'b0; in_tlast = 1'b0;
        step();
        chk("wr_busy_after_write", {63'd0, wr_busy}, 64'd0);
    endtask

    task automatic play(input int slot, input int rep, input int nwords,
                        input int stop_at, input bit contig);
        int hs = 0, first = -1, lastc = -1, cyc = 0;
        play_slot = 2'(slot); play_repeat = 8'(rep); play_start = 1'b1;
        step();
        play_start = 1'b0;
        while (cyc < 3000) begin
            if (out_tvalid) begin
                if (first < 0) first = cyc;
                lastc = cyc;
            end
            if (out_tvalid && out_tready) hs++;
            play_stop = (stop_at >= 0) && (hs == stop_at);
            if (!play_busy) break;
            step();
            cyc++;
        end
        play_stop = 1'b0;
        chk("play_busy_drop", {63'd0, play_busy}, 64'd0);
        chk("first_valid_latency_ok", {63'd0, 1'(first >= 0 && first <= 2)}, 64'd1);
        chk("word_count", 64'(hs), 64'(nwords));
        if (contig) chk("no_bubbles_span", 64'(lastc - first + 1), 64'(nwords));
        step();
        chk("tvalid_idle", {63'd0, out_tvalid}, 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) step();
        aresetn = 1'b1;
        step();
        chk("rst_slot_valid", 64'(slot_valid), 64'd0);
        chk("rst_busy", {62'd0, wr_busy, play_busy}, 64'd0);
        chk("rst_in_tready", {63'd0, in_tready}, 64'd0);
        chk("rst_out_tvalid", {63'd0, out_tvalid}, 64'd0);

        // Play of an empty slot is rejected.
        err_slot_cnt = 0; busy_seen = 0; tvalid_seen = 0;
        play_slot = 2'd3; play_start = 1'b1;
        step();
        play_start = 1'b0;
        repeat (5) step();
        chk("err_slot_pulses", 64'(err_slot_cnt), 64'd1);
        chk("err_slot_no_busy", 64'(busy_seen), 64'd0);
        chk("err_slot_no_tvalid", 64'(tvalid_seen), 64'd0);

        write_slot(1, 16, 16, 15, 0, -1);
        chk("w1_slot_valid", 64'(slot_valid), 64'h2);
        chk("w1_err_len", 64'(err_len_cnt), 64'd0);
        push_words(0, 16, 1);
        play(1, 1, 16, -1, 1'b1);

        write_slot(2, 8, 5, 4, 100, -1);
        chk("w2_err_len", 64'(err_len_cnt), 64'd1);
        chk("w2_slot_valid", 64'(slot_valid), 64'h6);
        push_words(100, 5, 1);
        play(2, 1, 5, -1, 1'b1);
        // Slot 1 must survive the slot 2 write; two back-to-back repetitions.
        push_words(0, 16, 2);
        play(1, 2, 32, -1, 1'b1);

        write_slot(3, 4, 4, -1, 300, -1);
        chk("w3_len_no_tlast_err", 64'(err_len_cnt), 64'd1);

        write_slot(0, 4, 4, 3, 0, -1);
        chk("w0_err_len", 64'(err_len_cnt), 64'd0);
        chk("w0_slot_valid", 64'(slot_valid), 64'hF);
        rnd_ready = 1'b1;
        push_words(0, 4, 3);
        play(0, 3, 12, -1, 1'b0);
        rnd_ready = 1'b0;
        step();

        push_words(0, 4, 2);
        play(0, 0, 8, 5, 1'b1);
        push_words(300, 4, 1);
        play(3, 1, 4, -1, 1'b1);

        // Asynchronous reset in the middle of a write.
        write_slot(1, 16, 16, 15, 500, 7);
        #1 aresetn = 1'b0;
        #1;
        chk("arst_slot_valid", 64'(slot_valid), 64'd0);
        chk("arst_flags", {58'd0, wr_busy, play_busy, err_len, err_slot, in_tready, out_tvalid}, 64'd0);
        chk("arst_tlast", {63'd0, out_tlast}, 64'd0);
        in_tvalid = 1'b0; in_tlast = 1'b0;
        step(); step();
        aresetn = 1'b1;
        step();
        write_slot(1, 16, 16, 15, 200, -1);
        chk("post_rst_slot_valid", 64'(slot_valid), 64'h2);
        chk("post_rst_err_len", 64'(err_len_cnt), 64'd0);
        push_words(200, 16, 1);
        play(1, 1, 16, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
